// File: rtl/audio_send.sv
// I2S transmitter for the WM8978 DAC input. Everything runs on aud_bclk;
// the codec is the I2S master and supplies aud_bclk and aud_lrc.
//
// Ports:
//   aud_bclk     - codec bit clock, the only clock (rising edge)
//   rst          - asynchronous active-high reset
//   aud_lrc      - codec L/R clock, 0 = left, 1 = right
//   aud_dacdat   - serial data to the codec, MSB first, one bclk after the lrc edge
//   dac_left     - left sample, qualified by dac_valid
//   dac_right    - right sample, qualified by dac_valid
//   dac_valid    - user frame valid
//   dac_ready    - frame buffer not full
//   mute         - transmit zeros (sampled on lrc edges); the buffer still drains
//   tx_done      - one-cycle pulse when a frame is popped for transmission
//   underrun     - sticky, set when a pop finds the buffer empty
//   underrun_cnt - saturating count of underrun events
module audio_send #(
  parameter logic [5:0] WL = 6'd32
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  output logic        aud_dacdat,
  input  logic [31:0] dac_left,
  input  logic [31:0] dac_right,
  input  logic        dac_valid,
  output logic        dac_ready,
  input  logic        mute,
  output logic        tx_done,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned WlInt = 32'(WL);

  logic        lrc_d0_q;
  logic [63:0] mem_q [2];  // {left, right}
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        ready_q;
  logic [31:0] hold_l_q, hold_l_d;
  logic [31:0] hold_r_q, hold_r_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        dacdat_q, dacdat_d;
  logic        tx_done_q, tx_done_d;
  logic        underrun_q, underrun_d;
  logic [15:0] ucnt_q, ucnt_d;

  logic        lrc_edge, fall, empty, push, pop;
  logic [63:0] head;
  logic [31:0] load_val;

  assign lrc_edge = aud_lrc ^ lrc_d0_q;
  assign fall     = lrc_edge & ~aud_lrc;
  assign empty    = (count_q == 2'd0);
  assign push     = dac_valid & ready_q;
  // Pop sees only entries present before this cycle: no push-to-pop bypass.
  assign pop      = fall & ~empty;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_comb begin
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    tx_done_d  = 1'b0;
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;
    if (fall) begin
      if (!empty) begin
        hold_l_d  = head[63:32];
        hold_r_d  = head[31:0];
        tx_done_d = 1'b1;
      end else begin
        hold_l_d   = '0;
        hold_r_d   = '0;
        underrun_d = 1'b1;
        if (ucnt_q != 16'hFFFF) begin
          ucnt_d = ucnt_q + 16'd1;
        end
      end
    end
  end

  // Serialiser: the edge cycle loads the word and drives its MSB; the shift
  // register then presents each lower bit at position WL-2.
  always_comb begin
    load_val  = fall ? hold_l_d : hold_r_q;
    if (mute) begin
      load_val = '0;
    end
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dacdat_d  = 1'b0;
    if (lrc_edge) begin
      shift_d   = load_val;
      dacdat_d  = load_val[WlInt-1];
      bit_cnt_d = 6'd1;
    end else if (bit_cnt_q < WL) begin
      dacdat_d  = shift_q[WlInt-2];
      shift_d   = shift_q << 1;
      bit_cnt_d = bit_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      lrc_d0_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ready_q    <= 1'b1;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= WL;
      dacdat_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      lrc_d0_q <= aud_lrc;
      if (push) begin
        mem_q[wr_ptr_q] <= {dac_left, dac_right};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      ready_q    <= (count_d != 2'd2);
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      dacdat_q   <= dacdat_d;
      tx_done_q  <= tx_done_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign aud_dacdat   = dacdat_q;
  assign dac_ready    = ready_q;
  assign tx_done      = tx_done_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_send.sv
`timescale 1ns/1ps
module tb_audio_send;

  typedef struct {
    logic [31:0] l, r;          // driven samples
    logic [31:0] l32, r32;      // expected serial words, 32-bit instance
    logic [31:0] l16, r16;      // expected serial words, 16-bit instance
  } frame_t;

  typedef struct {
    logic [31:0] left, right;
    logic        mute_l, mute_r;
    logic [31:0] exp_l32, exp_r32;
    logic [15:0] exp_l16, exp_r16;
  } vec_t;

  logic        clk, rst, lrc, valid, mute;
  logic [31:0] left, right;
  logic        dat_a, rdy_a, tx_a, ur_a;
  logic [15:0] uc_a;
  logic        dat_b, rdy_b, tx_b, ur_b;
  logic [15:0] uc_b;

  int tests, fails;

  // Reference model state
  frame_t      mq[$];
  logic [31:0] q32[$], q16[$];
  logic        m_lrc, m_tx, m_ur;
  int          m_uc;
  logic [31:0] hr32, hr16;
  frame_t      zf;

  audio_send #(.WL(6'd32)) u_a (
    .aud_bclk(clk), .rst(rst), .aud_lrc(lrc), .aud_dacdat(dat_a),
    .dac_left(left), .dac_right(right), .dac_valid(valid), .dac_ready(rdy_a),
    .mute(mute), .tx_done(tx_a), .underrun(ur_a), .underrun_cnt(uc_a)
  );

  audio_send #(.WL(6'd16)) u_b (
    .aud_bclk(clk), .rst(rst), .aud_lrc(lrc), .aud_dacdat(dat_b),
    .dac_left(left), .dac_right(right), .dac_valid(valid), .dac_ready(rdy_b),
    .mute(mute), .tx_done(tx_b), .underrun(ur_b), .underrun_cnt(uc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [31:0] l, input logic [31:0] r);
    frame_t f;
    f.l = l; f.r = r;
    f.l32 = l; f.r32 = r;
    f.l16 = l & 32'h0000_FFFF; f.r16 = r & 32'h0000_FFFF;
    return f;
  endfunction

  task automatic check_outputs();
    check("ready32", rdy_a, (mq.size() < 2));
    check("ready16", rdy_b, (mq.size() < 2));
    check("tx_done32", tx_a, m_tx);
    check("tx_done16", tx_b, m_tx);
    check("underrun32", ur_a, m_ur);
    check("underrun16", ur_b, m_ur);
    check("ucnt32", uc_a, m_uc);
    check("ucnt16", uc_b, m_uc);
  endtask

  // One bclk: check outputs of the last edge, drive inputs, advance the model.
  task automatic cycle(input logic l_in, input logic v_in, input frame_t f, input logic m_in,
                       output logic acc);
    logic   rdy_before, fall_e, rise_e;
    frame_t h;
    @(negedge clk);
    check_outputs();
    lrc = l_in; valid = v_in; left = f.l; right = f.r; mute = m_in;
    rdy_before = (mq.size() < 2);
    fall_e = (l_in != m_lrc) && !l_in;
    rise_e = (l_in != m_lrc) && l_in;
    m_tx = 1'b0;
    if (fall_e) begin
      if (mq.size() > 0) begin
        h = mq.pop_front();
        m_tx = 1'b1;
        hr32 = h.r32; hr16 = h.r16;
        q32.push_back(m_in ? 32'h0 : h.l32);
        q16.push_back(m_in ? 32'h0 : h.l16);
      end else begin
        m_ur = 1'b1;
        if (m_uc < 65535) m_uc++;
        hr32 = '0; hr16 = '0;
        q32.push_back(32'h0);
        q16.push_back(32'h0);
      end
    end
    if (rise_e) begin
      q32.push_back(m_in ? 32'h0 : hr32);
      q16.push_back(m_in ? 32'h0 : hr16);
    end
    acc = v_in && rdy_before;
    if (acc) mq.push_back(f);
    m_lrc = l_in;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(lrc, 1'b0, zf, 1'b0, acc);
  endtask

  task automatic push_hold(input frame_t f);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      cycle(lrc, 1'b1, f, 1'b0, acc);
      n++;
    end
    check("push_accepted", acc, 1'b1);
  endtask

  // 64-bclk stereo frame starting with a fall; mute toggles away from the
  // edges to show that only the edge-cycle value matters.
  task automatic run_frame(input logic ml, input logic mr, input logic pend, input frame_t f,
                           output int acc_at);
    logic acc, p, lv, m;
    p = pend;
    acc_at = -1;
    for (int i = 0; i < 64; i++) begin
      lv = (i >= 32);
      if (i == 0) m = ml;
      else if (i == 32) m = mr;
      else m = (i < 32) ? !ml : !mr;
      cycle(lv, p, f, m, acc);
      if (acc) begin
        p = 1'b0;
        acc_at = i;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_dacdat32", dat_a, 1'b0);
    check("rst_dacdat16", dat_b, 1'b0);
    check("rst_ready", rdy_a, 1'b1);
    check("rst_underrun", ur_a, 1'b0);
    check("rst_ucnt", uc_a, 16'd0);
    check("rst_tx_done", tx_a, 1'b0);
    mq.delete(); q32.delete(); q16.delete();
    m_lrc = 1'b0; m_tx = 1'b0; m_ur = 1'b0; m_uc = 0; hr32 = '0; hr16 = '0;
    lrc = 1'b0; valid = 1'b0; mute = 1'b0; left = '0; right = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Prime: a rise half so the next frame starts with a fall.
  task automatic prime();
    logic acc;
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, zf, 1'b0, acc);
  endtask

  // Receiver: collect bits after each lrc edge and compare complete words.
  int          mcnt [2];
  logic [31:0] mword [2];
  logic        mprev;
  always @(posedge clk) begin
    logic        ls, rs, d;
    int          w;
    logic [31:0] e;
    ls = lrc;
    rs = rst;
    #2;
    if (rs) begin
      mprev = 1'b0;
      mcnt[0] = 32;
      mcnt[1] = 16;
    end else begin
      for (int i = 0; i < 2; i++) begin
        w = (i == 0) ? 32 : 16;
        d = (i == 0) ? dat_a : dat_b;
        if (ls != mprev) begin
          mword[i] = {31'b0, d};
          mcnt[i] = 1;
        end else if (mcnt[i] < w) begin
          mword[i] = {mword[i][30:0], d};
          mcnt[i]++;
          if (mcnt[i] == w) begin
            if ((i == 0 && q32.size() == 0) || (i == 1 && q16.size() == 0)) begin
              tests++;
              fails++;
              $display("FAIL unexpected_word%0d: got %h expected none", w, mword[i]);
            end else begin
              e = (i == 0) ? q32.pop_front() : q16.pop_front();
              check((i == 0) ? "word32" : "word16", mword[i], e);
            end
          end
        end else begin
          check((i == 0) ? "pad32" : "pad16", {31'b0, d}, 32'h0);
        end
      end
      mprev = ls;
    end
  end

  initial begin
    vec_t   tbl [5];
    frame_t f;
    int     acc_at;
    logic   acc;

    tests = 0; fails = 0;
    zf = mk(32'h0, 32'h0);
    rst = 1'b1; lrc = 1'b0; valid = 1'b0; mute = 1'b0; left = '0; right = '0;

    tbl[0] = '{32'hA5A5_0F0F, 32'h8000_0001, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h8000_0001,
               16'h0F0F, 16'h0001};
    tbl[1] = '{32'h0000_1234, 32'h0000_8001, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_8001,
               16'h1234, 16'h8001};
    tbl[2] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF,
               16'h0000, 16'hFFFF};
    tbl[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0,
               16'h5678, 16'hDEF0};
    tbl[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000,
               16'hBEEF, 16'h0000};

    do_reset();
    prime();

    // Table-driven frames
    for (int k = 0; k < 5; k++) begin
      f.l = tbl[k].left; f.r = tbl[k].right;
      f.l32 = tbl[k].exp_l32; f.r32 = tbl[k].exp_r32;
      f.l16 = {16'h0, tbl[k].exp_l16}; f.r16 = {16'h0, tbl[k].exp_r16};
      push_hold(f);
      idle(2);
      run_frame(tbl[k].mute_l, tbl[k].mute_r, 1'b0, zf, acc_at);
    end
    check("no_underrun_after_table", ur_a, 1'b0);

    // Backpressure: three frames with no lrc activity
    push_hold(mk(32'h1111_1111, 32'h2222_2222));
    push_hold(mk(32'h3333_3333, 32'h4444_4444));
    for (int i = 0; i < 3; i++) cycle(lrc, 1'b1, mk(32'h5555_5555, 32'h6666_6666), 1'b0, acc);
    check("ready_low_when_full", rdy_a, 1'b0);
    check("third_held", acc, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, mk(32'h5555_5555, 32'h6666_6666), acc_at);
    check("third_accepted_after_fall", acc_at, 1);
    run_frame(1'b0, 1'b0, 1'b0, zf, acc_at);
    run_frame(1'b0, 1'b0, 1'b0, zf, acc_at);

    // Underrun across three falls, then a normal frame
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0, zf, acc_at);
    check("underrun_set", ur_a, 1'b1);
    check("underrun_cnt3", uc_a, 16'd3);
    push_hold(mk(32'hC0FF_EE00, 32'h0BAD_F00D));
    run_frame(1'b0, 1'b0, 1'b0, zf, acc_at);
    check("underrun_cnt_still3", uc_a, 16'd3);

    // Push into empty buffer on the fall cycle: underrun, sent next fall
    run_frame(1'b0, 1'b0, 1'b1, mk(32'h7E57_0001, 32'h7E57_0002), acc_at);
    check("fall_push_accepted_at_fall", acc_at, 0);
    check("fall_push_underrun_cnt", uc_b, 16'd4);
    run_frame(1'b0, 1'b0, 1'b0, zf, acc_at);

    // Reset mid-word with a queued frame
    push_hold(mk(32'hFEED_FACE, 32'hCAFE_BABE));
    push_hold(mk(32'h0123_4567, 32'h89AB_CDEF));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, zf, 1'b0, acc);
    do_reset();
    prime();
    push_hold(mk(32'h8000_0000, 32'h0000_0001));
    run_frame(1'b0, 1'b0, 1'b0, zf, acc_at);
    idle(40);
    check("words_drained32", q32.size(), 0);
    check("words_drained16", q16.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_send.md
Name: audio_send

Overview:
- I2S transmitter that serialises stereo PCM samples to the WM8978 DAC input (aud_dacdat).
- Runs entirely in the aud_bclk domain; the codec is I2S master and supplies aud_bclk and aud_lrc.
- The user side pushes stereo frames through a 2-entry frame buffer using a valid/ready handshake.
- Underruns are detected, zero-filled and counted.

Parameters:
- WL, 6'd32, audio word length in bits, legal range 16..32; only bits [WL-1:0] of each sample are transmitted.

Ports:
- aud_bclk  input  1  WM8978 bit clock; the only clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- aud_lrc  input  1  codec L/R clock; 0 = left channel, 1 = right channel.
- aud_dacdat  output  1  serial audio data to codec, MSB first.
- dac_left  input  32  left sample, valid with dac_valid.
- dac_right  input  32  right sample, valid with dac_valid.
- dac_valid  input  1  user frame valid.
- dac_ready  output  1  buffer can accept a frame (not full).
- mute  input  1  1 = transmit zeros; the frame buffer still drains normally.
- tx_done  output  1  one-cycle pulse when a frame is popped for transmission.
- underrun  output  1  sticky; set on the first pop attempt from an empty buffer.
- underrun_cnt  output  16  saturating count of underrun events.

Behaviour:
- Reset values:
  - aud_dacdat = 0, dac_ready = 1, tx_done = 0, underrun = 0, underrun_cnt = 0.
  - Buffer empty; holding left/right registers = 0; shift register = 0; aud_lrc_d0 = 0; bit counter = WL.
- Edge detect: lrc_edge = aud_lrc XOR aud_lrc_d0, where aud_lrc_d0 is aud_lrc registered on aud_bclk.
  - fall = edge with aud_lrc = 0; rise = edge with aud_lrc = 1.
- Frame buffer: 2-entry FIFO of {left, right}.
  - Write occurs when dac_valid & dac_ready. dac_ready = (count < 2), registered, updated the same cycle count changes.
  - Write when full is impossible because ready is low.
- Pop occurs on the fall cycle only, once per stereo frame.
  - Buffer non-empty: the head entry is loaded into the holding left/right registers and tx_done = 1 for that cycle.
  - Buffer empty: holding registers are loaded with 0, underrun is set, and underrun_cnt increments, saturating at 16'hFFFF. tx_done stays 0.
  - Push and pop in the same cycle: count is unchanged. There is no bypass: a push into an empty buffer on the fall cycle is not visible to that pop, so the pop counts as an underrun.
- Serialisation (I2S, one-bclk delay). The codec samples aud_dacdat on the rising aud_bclk that follows the edge cycle.
  - Edge cycle: the shift register loads the selected sample (fall: left from the value being popped this cycle, i.e. the FIFO head or 0; rise: holding right), zeroed if mute = 1.
  - Same edge cycle: aud_dacdat <= bit WL-1 of that value, and the bit counter resets to 1.
  - Each following cycle: while the counter is < WL, drive the next lower bit and increment; once the counter = WL, drive 0.
  - Exactly WL bits are driven per half-frame, then zeros until the next edge.
  - A half-frame shorter than WL bclks is truncated: the next edge reloads regardless of the counter.
- mute is sampled on the edge cycle only; a mid-word change has no effect until the next edge.
- Startup:
  - If aud_lrc = 1 on the first cycle after reset, a rise is detected and holding right (0) is sent.
  - No pop occurs until the first fall.
- Reset asserted mid-word: all state clears immediately, aud_dacdat = 0, and queued frames are lost.
- Latency: a frame accepted before a fall appears with its left MSB on aud_dacdat at that fall cycle and its right MSB at the next rise cycle.

Test Plan:
- Normal frame: WL = 32, 64 bclk per frame; push L = 32'hA5A5_0F0F, R = 32'h8000_0001 before a fall.
  - aud_dacdat carries A5A50F0F MSB-first from the fall cycle, then 80000001 from the rise cycle.
  - tx_done pulses once at the fall; a receiver loopback recovers both words.
- Backpressure: push 3 frames back-to-back with no LRC activity.
  - dac_ready drops after the 2nd write; the 3rd frame is held.
  - Ready returns the cycle after the first fall; frames come out in order.
- Underrun: no frames queued across 3 falls.
  - aud_dacdat stays all zeros; underrun = 1; underrun_cnt = 3; tx_done never pulses.
  - Push one frame: it transmits normally.
- Mute and short word: WL = 16, push L = 16'h1234 with mute = 1, then R = 16'h8001 with mute = 0 at the rise.
  - Left half is zeros; right sends 8001 over 16 bits followed by 16 zero bits; the buffer still drains.
- Corner cases:
  - Push into an empty buffer on the exact fall cycle: that fall counts as an underrun, and the frame goes out on the next fall.
  - Assert rst mid-word: aud_dacdat = 0 immediately, dac_ready = 1, counters cleared.
